window_builder: RTL

WINDOW_BUILDER -- requirements
Module: window_builder

---
 rtl/window_builder.sv | 105 ++++++++++
 1 files changed

// File: rtl/window_builder.sv
// window_builder: 3x3 RGB sliding-window generator over a raster pixel stream.
// Optional WB_FRAME_DONE_EN adds a one-cycle frame_done pulse after the last pixel.
module window_builder #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [23:0]  pixel_in,
    input  logic         pixel_valid,
    output logic         pixel_ready,
    output logic [215:0] pixelData,
    output logic         win_valid,
`ifdef WB_FRAME_DONE_EN
    output logic         frame_done,
`endif
    input  logic         win_ready
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    typedef enum logic {FILL, STREAM} state_e;
    state_e state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [23:0] lb0_q [IMG_WIDTH];
    logic [23:0] lb1_q [IMG_WIDTH];
    logic [23:0] win_q [9];
    logic [23:0] win_d [9];
    logic [215:0] data_q, data_d;
    logic valid_q, valid_d;
    logic accept, col_last, row_last, form;

    assign pixel_ready = !valid_q || win_ready;
    assign accept      = pixel_valid && pixel_ready;
    assign col_last    = col_q == CW'(IMG_WIDTH - 1);
    assign row_last    = row_q == RW'(IMG_HEIGHT - 1);
    assign pixelData   = data_q;
    assign win_valid   = valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = !(accept && col_last) ? state_q :
                  state_q == FILL ? (row_q == RW'(1) ? STREAM : FILL) :
                  (row_last ? FILL : STREAM);
    end

    // Only a STREAM pixel at col >= 2 completes a window, so stale columns never leak.
    always_comb begin
        form = accept && state_q == STREAM && col_q >= CW'(2);
    end

    always_comb begin
        col_d = accept ? (col_last ? '0 : col_q + 1'b1) : col_q;
        row_d = (accept && col_last) ? (row_last ? '0 : row_q + 1'b1) : row_q;
        for (int i = 0; i < 9; i++) win_d[i] = win_q[i];
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]   = win_q[3*r+1];
                win_d[3*r+1] = win_q[3*r+2];
            end
            win_d[2] = lb1_q[col_q];
            win_d[5] = lb0_q[col_q];
            win_d[8] = pixel_in;
        end
        data_d  = form ? {win_d[0], win_d[1], win_d[2], win_d[3], win_d[4],
                          win_d[5], win_d[6], win_d[7], win_d[8]} : data_q;
        valid_d = form || (valid_q && !win_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Line buffers and the shift window carry no reset: their contents are rebuilt before use.
    always_ff @(posedge clk) begin
        win_q <= win_d;
        if (accept) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= pixel_in;
        end
    end

`ifdef WB_FRAME_DONE_EN
    logic done_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_q <= 1'b0;
        else     done_q <= accept && col_last && row_last;
    end
    assign frame_done = done_q;
`endif
endmodule
